// File: rtl/systolic_feeder.sv
// Operand store and diagonal-skew streamer feeding a SIZE x SIZE systolic array.
// Optional macro SYSTOLIC_FEEDER_TRANSPOSE_B_EN stores B writes transposed (B[col][row]).
module systolic_feeder #(
  parameter int SIZE         = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [$clog2(SIZE)-1:0]      wr_row,
  input  logic [$clog2(SIZE)-1:0]      wr_col,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         array_clr,
  output logic [SIZE*DATA_WIDTH-1:0]   out_west,
  output logic [SIZE*DATA_WIDTH-1:0]   out_north
);

  localparam int AW       = $clog2(SIZE);
  localparam int KW       = $clog2(3*SIZE);
  localparam int FEED_LEN = 3*SIZE - 2;
  localparam int DCW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(FEED_LEN - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic signed [DATA_WIDTH-1:0] a_q [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] a_d [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] b_q [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] b_d [SIZE][SIZE];
  logic [SIZE*DATA_WIDTH-1:0] west_q, west_d, north_q, north_d;
  logic busy_q, busy_d, done_q, done_d, clr_q, clr_d;
  logic           lanes_en;
  logic [KW-1:0]  k_lane;
  int             idx;

  assign busy      = busy_q;
  assign done      = done_q;
  assign array_clr = clr_q;
  assign out_west  = west_q;
  assign out_north = north_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    dcnt_d   = dcnt_q;
    lanes_en = 1'b0;
    k_lane   = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          k_d     = '0;
        end
      end
      CLEAR: begin
        state_d  = FEED;
        k_d      = '0;
        lanes_en = 1'b1;
        k_lane   = '0;
      end
      FEED: begin
        if (k_q == K_LAST) begin
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d      = k_q + KW'(1);
          lanes_en = 1'b1;
          k_lane   = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) state_d = DONE;
        else                  dcnt_d  = dcnt_q + DCW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR) || (state_d == FEED) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    clr_d  = (state_d == CLEAR);
  end

  // Lane values for the upcoming cycle; the index is widened to int so k-r < 0 stays negative.
  always_comb begin
    west_d  = '0;
    north_d = '0;
    idx     = 0;
    if (lanes_en) begin
      for (int r = 0; r < SIZE; r++) begin
        idx = int'(k_lane) - r;
        if (idx >= 0 && idx < SIZE) begin
          west_d[r*DATA_WIDTH +: DATA_WIDTH]  = a_q[r][idx[AW-1:0]];
          north_d[r*DATA_WIDTH +: DATA_WIDTH] = b_q[idx[AW-1:0]][r];
        end
      end
    end
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_en && !busy_q) begin
      if (!wr_sel) begin
        a_d[wr_row][wr_col] = $signed(wr_data);
      end else begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
        b_d[wr_col][wr_row] = $signed(wr_data);
`else
        b_d[wr_row][wr_col] = $signed(wr_data);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      west_q  <= '0;
      north_q <= '0;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      west_q  <= west_d;
      north_q <= north_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: lane scoreboard plus a behavioural 4x4 output-stationary array.
module tb_systolic_feeder;
  localparam int SIZE = 4;
  localparam int DW   = 8;
  localparam int LW   = SIZE*DW;
  localparam int NK   = 3*SIZE - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [1:0] wr_row = '0, wr_col = '0;
  logic [7:0] wr_data = '0;
  logic busy, done, array_clr;
  logic [LW-1:0] out_west, out_north;

  int total = 0;
  int bad   = 0;

  logic signed [7:0] ma [SIZE][SIZE];
  logic signed [7:0] mb [SIZE][SIZE];
  int                acc [SIZE][SIZE];
  logic signed [7:0] ar [SIZE][SIZE];
  logic signed [7:0] br [SIZE][SIZE];
  logic signed [7:0] ain, bin;
  logic [LW-1:0] qw[$], qn[$];
  logic [LW-1:0] cap_w [NK];
  logic [LW-1:0] cap_n [NK];

  always #5 clk = ~clk;

  systolic_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .DRAIN_CYCLES(SIZE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .array_clr(array_clr), .out_west(out_west), .out_north(out_north)
  );

  // Behavioural systolic array: operands move east/south one PE per clock, PEs accumulate.
  always @(posedge clk) begin
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (rst || array_clr) begin
          acc[r][c] <= 0;
          ar[r][c]  <= '0;
          br[r][c]  <= '0;
        end else begin
          ain = (c == 0) ? $signed(out_west[r*DW +: DW]) : ar[r][(c > 0) ? c-1 : 0];
          bin = (r == 0) ? $signed(out_north[c*DW +: DW]) : br[(r > 0) ? r-1 : 0][c];
          acc[r][c] <= acc[r][c] + int'(ain) * int'(bin);
          ar[r][c]  <= ain;
          br[r][c]  <= bin;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack4(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [LW-1:0] exp_west(input int k);
    logic [LW-1:0] v = '0;
    for (int r = 0; r < SIZE; r++) begin
      int i = k - r;
      if (i >= 0 && i < SIZE) v[r*DW +: DW] = ma[r][i];
    end
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_north(input int k);
    logic [LW-1:0] v = '0;
    for (int c = 0; c < SIZE; c++) begin
      int i = k - c;
      if (i >= 0 && i < SIZE) v[c*DW +: DW] = mb[i][c];
    end
    return v;
  endfunction

  task automatic load_all();
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'(r); wr_col = 2'(c); wr_data = ma[r][c];
        @(negedge clk);
      end
    end
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = mb[r][c];
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
        wr_row = 2'(c); wr_col = 2'(r);
`else
        wr_row = 2'(r); wr_col = 2'(c);
`endif
        @(negedge clk);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic zero_models();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  // Entered just after a negedge; start is sampled at the following posedge.
  task automatic run(input string tag, input bit disturb);
    int done_at = -1;
    int bcnt = 0;
    int ccnt = 0;
    int n = 0;
    bit seen = 0;
    int expm;
    for (int k = 0; k < NK; k++) begin
      qw.push_back(exp_west(k));
      qn.push_back(exp_north(k));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (array_clr) ccnt++;
      if (busy) bcnt++;
      if (seen && qw.size() > 0) begin
        check({tag, "_west"}, 64'(out_west), 64'(qw.pop_front()));
        check({tag, "_north"}, 64'(out_north), 64'(qn.pop_front()));
        cap_w[n] = out_west;
        cap_n[n] = out_north;
        n++;
      end else if (seen && !done) begin
        check({tag, "_drain_lanes"}, 64'({out_west, out_north}), 64'(0));
      end
      if (array_clr) seen = 1;
      if (done) begin
        done_at = cyc;
        break;
      end
      if (disturb && cyc == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h7F;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, "_done_latency"}, 64'(done_at), 64'(16));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(15));
    check({tag, "_clr_cycles"}, 64'(ccnt), 64'(1));
    check({tag, "_sb_empty"}, 64'(qw.size()), 64'(0));
    qw.delete();
    qn.delete();
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        expm = 0;
        for (int i = 0; i < SIZE; i++) expm += int'(ma[r][i]) * int'(mb[i][c]);
        check({tag, "_result_raw"}, 64'(acc[r][c]), 64'(expm));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int dcnt;
    zero_models();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_lanes", 64'({out_west, out_north}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_clr", 64'(array_clr), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Identity A, B = 1..16: product equals B.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        ma[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        mb[r][c] = 8'(4*r + c + 1);
      end
    load_all();
    run("ident", 0);
    check("ident_r23", 64'(acc[2][3]), 64'(12));

    // Skew pattern with distinguishable A entries.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) ma[r][c] = 8'(10*r + c + 1);
    load_all();
    run("skew", 0);
    check("skew_w_k0", 64'(cap_w[0]), 64'(pack4(8'd1, 8'd0, 8'd0, 8'd0)));
    check("skew_w_k1", 64'(cap_w[1]), 64'(pack4(8'd2, 8'd11, 8'd0, 8'd0)));
    check("skew_w_k3", 64'(cap_w[3]), 64'(pack4(8'd4, 8'd13, 8'd22, 8'd31)));
    check("skew_w_k9", 64'(cap_w[9]), 64'(0));
    check("skew_n_k0", 64'(cap_n[0]), 64'(pack4(8'd1, 8'd0, 8'd0, 8'd0)));
    check("skew_n_k3", 64'(cap_n[3]), 64'(pack4(8'd13, 8'd10, 8'd7, 8'd4)));

    // All twos: every output 16.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        ma[r][c] = 8'sd2;
        mb[r][c] = 8'sd2;
      end
    load_all();
    run("twos", 0);
    check("twos_r33", 64'(acc[3][3]), 64'(16));

    // Signed operands: -1 x 3 accumulated four times.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        ma[r][c] = -8'sd1;
        mb[r][c] = 8'sd3;
      end
    load_all();
    run("signed", 0);
    check("signed_raw00", 64'(acc[0][0]), 64'(-12));
    check("signed_relu00", 64'((acc[0][0] < 0) ? 0 : acc[0][0]), 64'(0));

    // Start and write while busy are ignored; a rerun repeats the same lanes.
    run("protocol", 1);
    run("rerun", 0);
    check("rerun_a00_kept", 64'(cap_w[0]), 64'(pack4(8'hFF, 8'd0, 8'd0, 8'd0)));

    // Reset during FEED: lanes clear at once and no done follows.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midfeed_lanes_live", 64'(out_west != '0), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("midfeed_rst_lanes", 64'({out_west, out_north}), 64'(0));
    check("midfeed_rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midfeed_no_done", 64'(dcnt), 64'(0));
    zero_models();

`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
    wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd0; wr_col = 2'd2; wr_data = 8'd5;
    @(negedge clk);
    wr_en = 1'b0;
    mb[2][0] = 8'sd5;
    run("transpose", 0);
    check("transpose_n_k2", 64'(cap_n[2]), 64'(pack4(8'd5, 8'd0, 8'd0, 8'd0)));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Transmit-side companion of the 4x4 systolic array: stores operand matrices A (west) and B (north) and streams them diagonally skewed into the array's in_west/in_north ports. The block pulses a clear to the array's accumulators, feeds all skewed wavefronts, and waits for the pipeline to drain. It then flags that the array's result/result_raw are final. It sits between the NPU load path and the systolic_array instance.

Parameters:
SIZE, 4, array dimension (rows = cols)
DATA_WIDTH, 8, signed operand width
DRAIN_CYCLES, SIZE, zero-input cycles after last wavefront before done

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write one operand element
wr_sel  input  1  0 = matrix A, 1 = matrix B
wr_row  input  $clog2(SIZE)  element row index
wr_col  input  $clog2(SIZE)  element column index
wr_data  input  DATA_WIDTH  signed element value
start  input  1  begin a multiply run (sampled in IDLE only)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse: array results are final
array_clr  output  1  one-cycle clear pulse, OR'd into the array's rst by the top level
out_west  output  SIZE x DATA_WIDTH signed  drives array in_west[0:SIZE-1]
out_north  output  SIZE x DATA_WIDTH signed  drives array in_north[0:SIZE-1]

Behaviour:
- Reset (async, any state) clears the following to 0: state=IDLE, all A/B storage, k counter, busy, done, array_clr, every out_west/out_north lane.
- Storage is two SIZE x SIZE register arrays.
  - A write (wr_en=1) is accepted only while not busy and takes effect at the next clk edge.
  - Writes while busy are ignored.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 moves to CLEAR next cycle and sets busy=1.
  - A same-cycle wr_en is still accepted, because start is sampled with busy=0.
- CLEAR, exactly 1 cycle:
  - array_clr=1.
  - All lanes are 0.
  - k is reset to 0.
  - Next state is FEED.
- FEED, exactly 3*SIZE-2 cycles, k = 0..3*SIZE-3, lanes registered:
  - out_west[r] = A[r][k-r] if 0 <= k-r < SIZE, else 0.
  - out_north[c] = B[k-c][c] if 0 <= k-c < SIZE, else 0.
  - After the cycle with k = 3*SIZE-3, the next state is DRAIN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles.
  - All lanes are 0, so the PEs accumulate nothing further.
  - Next state is DONE.
- DONE, 1 cycle:
  - done=1 and busy is cleared the same cycle.
  - Next state is IDLE.
  - Total run = 1 + (3*SIZE-2) + DRAIN_CYCLES + 1 cycles from the start sample (SIZE=4: 16).
- start is ignored while busy; no queueing.
- Stored matrices persist across runs. A second start without writes reproduces identical lane sequences.
- k width is $clog2(3*SIZE) bits. The index arithmetic must use signed or widened compares so that k-r < 0 never wraps.
- Reset asserted mid-FEED: lanes go to 0 immediately and asynchronously, and no done pulse is emitted.

Optional Feature:
SYSTOLIC_FEEDER_TRANSPOSE_B_EN
- Defined: writes with wr_sel=1 store to B[wr_col][wr_row]. Software can then load B column-major (the same layout as A rows), and the array computes A x B^T of the written data.
- Undefined: B is stored at B[wr_row][wr_col]. All other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-idle, then release -> all lanes=0, busy=0, done=0, array_clr=0. Load A=I, B[r][c]=4r+c+1 and start. Expect:
  - array_clr high exactly 1 cycle after start.
  - done exactly 16 cycles after start, busy high for 15 cycles.
- Skew check: A[r][c]=10r+c+1 with the same start. Expect:
  - FEED k=0: out_west={1,0,0,0}.
  - k=1: {2,11,0,0}.
  - k=3: {4,13,22,31}.
  - k=9: {0,0,0,0}.
  - out_north follows the mirrored pattern from B.
- End-to-end: feeder driving systolic_array. A = B = all 2 -> every result_raw = 16 at done. A=I, B=1..16 -> result equals B.
- Signed/ReLU: A = all -1, B = all 3 -> result_raw = -12 (0xFFFFFFF4) and ReLU result = 0 at done.
- Protocol: start pulsed again during FEED, and wr_en with data 0x7F during FEED. Expect:
  - No restart, the lanes are unchanged, and the stored element still holds its old value.
  - Reset mid-FEED gives lanes=0 and no done pulse.
- Feature: with SYSTOLIC_FEEDER_TRANSPOSE_B_EN, write (wr_sel=1,row=0,col=2,data=5) -> B[2][0]=5, visible on out_north[0] at k=2.
